// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM states and constants for the multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MSUB  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 8;

    function automatic logic opIsDiv(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic opIsMove(input logic [2:0] op);
        return (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative unsigned 32/32 restoring divider: one quotient bit per cycle, 32 cycles after load.
module muldiv_divider
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_valid
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_divisor;
    logic [5:0]  r_count;
    logic        r_valid;

    logic [32:0] w_shifted;
    logic [32:0] w_diff;

    // The partial remainder is always below the divisor, so one extra bit holds the shifted value.
    assign w_shifted = {r_rem, r_quo[31]};
    assign w_diff    = w_shifted - {1'b0, r_divisor};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
        end else if (i_load) begin
            r_rem     <= '0;
            r_quo     <= i_dividend;
            r_divisor <= i_divisor;
            r_count   <= 6'(DIV_ITERS);
            r_valid   <= 1'b0;
        end else if (r_count != 6'd0) begin
            if (w_diff[32]) begin
                r_rem <= w_shifted[31:0];
                r_quo <= {r_quo[30:0], 1'b0};
            end else begin
                r_rem <= w_diff[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end
            r_count <= r_count - 6'd1;
            r_valid <= (r_count == 6'd1);
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_valid     = r_valid;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer; sole owner of the architectural HI/LO pair.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [63:0]        r_mulA;
    logic [63:0]        r_mulB;
    logic               r_quoNeg;
    logic               r_remNeg;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_issue;
    logic               w_divSigned;
    logic [31:0]        w_divA;
    logic [31:0]        w_divB;
    logic [31:0]        w_quotient;
    logic [31:0]        w_remainder;
    logic               w_divValid;
    logic [63:0]        w_prod;
    logic [63:0]        w_mulResult;
    logic [31:0]        w_quoFix;
    logic [31:0]        w_remFix;

    assign w_issue     = (r_state == S_IDLE) && start && !cancel;
    assign w_divSigned = (op == OP_DIV);
    assign w_divA      = (w_divSigned && a[31]) ? (32'd0 - a) : a;
    assign w_divB      = (w_divSigned && b[31]) ? (32'd0 - b) : b;

    muldiv_divider u_divider (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_issue && opIsDiv(op)),
        .i_dividend  (w_divA),
        .i_divisor   (w_divB),
        .o_quotient  (w_quotient),
        .o_remainder (w_remainder),
        .o_valid     (w_divValid)
    );

    // Operands are pre-extended to 64 bits, so a plain low-64 product serves both signed and unsigned ops.
    assign w_prod = r_mulA * r_mulB;

    always_comb begin
        w_mulResult = w_prod;
        case (r_op)
            OP_MADD: w_mulResult = {r_hi, r_lo} + w_prod;
            OP_MSUB: w_mulResult = {r_hi, r_lo} - w_prod;
            default: w_mulResult = w_prod;
        endcase
    end

    assign w_quoFix = r_quoNeg ? (32'd0 - w_quotient)  : w_quotient;
    assign w_remFix = r_remNeg ? (32'd0 - w_remainder) : w_remainder;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_mulA   <= '0;
            r_mulB   <= '0;
            r_quoNeg <= 1'b0;
            r_remNeg <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_op <= op;
                        if (op == OP_MTHI) begin
                            r_hi <= a;
                        end else if (op == OP_MTLO) begin
                            r_lo <= a;
                        end else if (opIsDiv(op)) begin
                            r_state  <= S_DIV;
                            r_busy   <= 1'b1;
                            r_cnt    <= CNT_W'(DIV_ITERS - 1);
                            r_quoNeg <= w_divSigned && (a[31] ^ b[31]);
                            r_remNeg <= w_divSigned && a[31];
                        end else begin
                            r_state <= S_MUL;
                            r_busy  <= 1'b1;
                            r_cnt   <= CNT_W'(MUL_LAT - 1);
                            r_mulA  <= (op == OP_MULTU) ? {32'd0, a} : {{32{a[31]}}, a};
                            r_mulB  <= (op == OP_MULTU) ? {32'd0, b} : {{32{b[31]}}, b};
                        end
                    end
                end
                S_MUL: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        {r_hi, r_lo} <= w_mulResult;
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DIV: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    // The divider finishes on the same edge the FSM enters FIX, so valid is already set here.
                    if (cancel) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_divValid) begin
                        r_hi    <= w_remFix;
                        r_lo    <= w_quoFix;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against an arithmetic HI/LO reference model.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  opIn;
    logic [31:0] aIn;
    logic [31:0] bIn;
    logic        cancel;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int          vectors;
    int          miscompares;
    logic [31:0] mHi;
    logic [31:0] mLo;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (opIn),
        .a      (aIn),
        .b      (bIn),
        .cancel (cancel),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic int latencyOf(input logic [2:0] op);
        if (op == OP_MTHI || op == OP_MTLO) return 0;
        if (op == OP_DIV || op == OP_DIVU) return DIV_LAT;
        return MUL_LAT;
    endfunction

    // Reference: architectural result of one op from the current HI/LO, using plain integer arithmetic.
    function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] h, input logic [31:0] l,
                                     output logic [31:0] nh, output logic [31:0] nl);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [63:0] acc;
        int          ia;
        int          ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = int'(a);
        ib = int'(b);
        acc = {h, l};
        nh = h;
        nl = l;
        case (op)
            OP_MULT:  begin p = 64'(sa * sb); {nh, nl} = p; end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; {nh, nl} = p; end
            OP_MADD:  begin p = 64'(sa * sb); {nh, nl} = acc + p; end
            OP_MSUB:  begin p = 64'(sa * sb); {nh, nl} = acc - p; end
            OP_DIV: begin
                if (b == 32'd0) begin
                    nl = a[31] ? 32'd1 : 32'hFFFFFFFF;
                    nh = a;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    nl = 32'h80000000;
                    nh = 32'd0;
                end else begin
                    nl = 32'(ia / ib);
                    nh = 32'(ia % ib);
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    nl = 32'hFFFFFFFF;
                    nh = a;
                end else begin
                    nl = a / b;
                    nh = a % b;
                end
            end
            OP_MTHI: nh = a;
            default: nl = a;
        endcase
    endfunction

    // Issue one op at the current negedge; returns at the done-cycle negedge (or after the cancel watch window).
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int cancelAt, input int pulseAt);
        logic [31:0] eHi;
        logic [31:0] eLo;
        int          lat;
        int          k;
        int          donePulses;
        logic        windowOk;
        logic        cancelled;
        refModel(op, a, b, mHi, mLo, eHi, eLo);
        lat = latencyOf(op);
        start = 1'b1;
        opIn  = op;
        aIn   = a;
        bIn   = b;
        @(negedge clk);
        start = 1'b0;
        aIn   = $urandom;
        bIn   = $urandom;
        if (lat == 0) begin
            mHi = eHi;
            mLo = eLo;
            checkOutput("moveHi", 64'(hi), 64'(mHi));
            checkOutput("moveLo", 64'(lo), 64'(mLo));
            checkOutput("moveBusy", 64'(busy), 64'd0);
            checkOutput("moveDone", 64'(done), 64'd0);
            return;
        end
        k = 0;
        windowOk = 1'b1;
        cancelled = 1'b0;
        while (k < lat && !cancelled) begin
            if (busy !== 1'b1 || done !== 1'b0) windowOk = 1'b0;
            if (k == pulseAt) begin
                start = 1'b1;
                opIn  = 3'($urandom_range(0, 7));
                aIn   = $urandom;
                bIn   = $urandom;
            end
            if (k == cancelAt) cancel = 1'b1;
            @(negedge clk);
            start = 1'b0;
            k++;
            if (cancel) begin
                cancel = 1'b0;
                cancelled = 1'b1;
            end
        end
        checkOutput("busyWindow", 64'(windowOk), 64'd1);
        if (cancelled) begin
            checkOutput("cancelBusy", 64'(busy), 64'd0);
            checkOutput("cancelHi", 64'(hi), 64'(mHi));
            checkOutput("cancelLo", 64'(lo), 64'(mLo));
            donePulses = 0;
            for (int i = 0; i < lat + 2; i++) begin
                if (done) donePulses++;
                @(negedge clk);
            end
            checkOutput("cancelNoDone", 64'(donePulses), 64'd0);
            checkOutput("cancelHold", {hi, lo}, {mHi, mLo});
        end else begin
            mHi = eHi;
            mLo = eLo;
            checkOutput("donePulse", 64'(done), 64'd1);
            checkOutput("doneBusy", 64'(busy), 64'd0);
            checkOutput("resultHi", 64'(hi), 64'(mHi));
            checkOutput("resultLo", 64'(lo), 64'(mLo));
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat;
        int          cancelAt;
        int          pulseAt;
        logic [2:0]  rop;
        vectors = 0;
        miscompares = 0;
        mHi = '0;
        mLo = '0;
        rst = 1'b1;
        start = 1'b0;
        cancel = 1'b0;
        opIn = '0;
        aIn = '0;
        bIn = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rstHi", 64'(hi), 64'd0);
        checkOutput("rstLo", 64'(lo), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstDone", 64'(done), 64'd0);

        applyStimulus(OP_MULT, 32'hFFFFFFFE, 32'hFFFFFFFE, -1, -1);
        checkOutput("multConst", {hi, lo}, 64'd4);

        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'd2, -1, -1);
        checkOutput("multuConst", {hi, lo}, 64'h00000001_FFFFFFFE);
        applyStimulus(OP_MTHI, 32'hFFFFFFFF, 32'd0, -1, -1);
        applyStimulus(OP_MSUB, 32'd3, 32'hFFFFFFFC, -1, -1);
        checkOutput("msubConst", {hi, lo}, 64'h00000000_0000000A);

        applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, -1, -1);
        checkOutput("divConst", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        applyStimulus(OP_DIVU, 32'd5, 32'd0, -1, -1);
        checkOutput("divuZero", {hi, lo}, 64'h00000005_FFFFFFFF);
        applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, -1);
        checkOutput("divOvf", {hi, lo}, 64'h00000000_80000000);

        @(negedge clk);
        applyStimulus(OP_DIV, 32'd1000, 32'd7, 9, -1);
        applyStimulus(OP_MTLO, 32'h1234, 32'd0, -1, -1);
        checkOutput("mtloConst", 64'(lo), 64'h1234);

        applyStimulus(OP_DIV, 32'd100, 32'hFFFFFFFD, -1, 5);
        applyStimulus(OP_MULT, 32'h12345678, 32'hFEDCBA98, -1, -1);
        applyStimulus(OP_MADD, 32'h7FFFFFFF, 32'h80000000, -1, -1);

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            lat = latencyOf(rop);
            cancelAt = -1;
            pulseAt = -1;
            if (lat > 0 && $urandom_range(0, 7) == 0) cancelAt = $urandom_range(0, lat - 1);
            if (lat >= 2 && $urandom_range(0, 3) == 0) pulseAt = $urandom_range(0, lat - 2);
            applyStimulus(rop, pickOperand(), pickOperand(), cancelAt, pulseAt);
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
                checkOutput("doneDrop", 64'(done), 64'd0);
            end
        end

        applyStimulus(OP_MTHI, 32'hCAFEF00D, 32'd0, -1, -1);
        start = 1'b1;
        opIn  = OP_DIV;
        aIn   = $urandom;
        bIn   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mHi = '0;
        mLo = '0;
        checkOutput("midRstHi", 64'(hi), 64'd0);
        checkOutput("midRstLo", 64'(lo), 64'd0);
        checkOutput("midRstBusy", 64'(busy), 64'd0);
        checkOutput("midRstDone", 64'(done), 64'd0);
        applyStimulus(OP_MULTU, 32'd6, 32'd7, -1, -1);
        checkOutput("postRst", {hi, lo}, 64'd42);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
